// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared writeback widths, entry type and rd decode helper
package wb_arbiter_pkg;
  localparam int RA_W = 5;
  localparam int XLEN = 32;
  localparam logic [RA_W-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;
  function automatic logic [31:0] rd_decode(input logic [RA_W-1:0] rd);
    return (32'd1 << rd) & ~32'd1;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous entry FIFO exposing per-entry valid and rd for hazard tracking
module wb_fifo import wb_arbiter_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W = RA_W + wb_arbiter_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [DEPTH-1:0]         vld,
  output logic [RA_W-1:0]          rds [DEPTH]
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;
  assign dout  = mem[rptr];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // an entry is live when its distance from the read pointer is below count
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [AW-1:0] off;
    assign off    = AW'(i) - rptr;
    assign vld[i] = {1'b0, off} < count;
    assign rds[i] = mem[i][W-1 -: RA_W];
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and long-latency results onto the regfile write port
// WB_ARBITER_BYPASS_EN lets port B skip an empty FIFO when port A is idle
module wb_arbiter import wb_arbiter_pkg::*; #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 4,
  parameter int XLEN       = wb_arbiter_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            we3,
  output logic [4:0]      wa3,
  output logic [XLEN-1:0] wd3,
  output logic [31:0]     pending,
  output logic            fifo_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int W  = RA_W + XLEN;
  logic [W-1:0] head;
  logic [AW:0] count;
  logic empty, push, pop, a_win, byp, win, force_drain;
  logic [DEPTH-1:0] vld;
  logic [RA_W-1:0] rds [DEPTH];
  logic [SW-1:0] starve;
  logic [RA_W-1:0] win_rd;
  logic [XLEN-1:0] win_data;
  wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk(clk), .rstn(rstn), .push(push), .pop(pop), .din({b_rd, b_data}),
    .dout(head), .count(count), .full(fifo_full), .empty(empty), .vld(vld), .rds(rds)
  );
  assign force_drain = !empty && starve == SW'(STARVE_MAX);
  assign a_ready     = !force_drain;
  assign a_win       = a_valid && a_ready;
  assign pop         = !a_win && !empty;
  assign b_ready     = !fifo_full || pop;
`ifdef WB_ARBITER_BYPASS_EN
  assign byp      = empty && !a_win && b_valid;
  assign win_rd   = a_win ? a_rd : pop ? head[W-1 -: RA_W] : b_rd;
  assign win_data = a_win ? a_data : pop ? head[XLEN-1:0] : b_data;
`else
  assign byp      = 1'b0;
  assign win_rd   = a_win ? a_rd : head[W-1 -: RA_W];
  assign win_data = a_win ? a_data : head[XLEN-1:0];
`endif
  assign push = b_valid && b_ready && !byp;
  assign win  = a_win || pop || byp;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) starve <= '0;
    else if (pop || empty) starve <= '0;
    else if (a_win && starve != SW'(STARVE_MAX)) starve <= starve + SW'(1);
  // x0 results are consumed but never raise we3
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else begin
      we3 <= win && win_rd != REG_ZERO;
      if (win) begin
        wa3 <= win_rd;
        wd3 <= win_data;
      end
    end
  always_comb begin
    pending = we3 ? rd_decode(wa3) : '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i]) pending = pending | rd_decode(rds[i]);
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: vector table plus write-order scoreboard for wb_arbiter
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;
  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  brd;
    logic [31:0] bd;
    logic        ear, ebr, ef, ewe;
    logic [4:0]  ewa;
    logic [31:0] epend;
  } vec_t;
  logic clk = 1'b0, rstn = 1'b0;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0] a_rd = '0, b_rd = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic a_ready, b_ready, we3, fifo_full;
  logic [4:0] wa3;
  logic [31:0] wd3, pending;
  int checks = 0, errors = 0;
  wb_entry_t qa[$], qb[$];
  vec_t tbl[$];
  always #5 clk = ~clk;
  wb_arbiter dut (
    .clk(clk), .rstn(rstn),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .we3(we3), .wa3(wa3), .wd3(wd3), .pending(pending), .fifo_full(fifo_full)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // accepted results enter the queues; each emitted write is matched in order (A data carries bit 31)
  task automatic tick();
    wb_entry_t e;
    if (a_valid && a_ready && a_rd != 5'd0) qa.push_back('{rd: a_rd, data: a_data});
    if (b_valid && b_ready && b_rd != 5'd0) qb.push_back('{rd: b_rd, data: b_data});
    @(posedge clk);
    #1;
    if (we3) begin
      if (wd3[31] ? qa.size() == 0 : qb.size() == 0) chk("sb_unexpected_write", {27'd0, wa3, wd3}, 64'd0);
      else begin
        e = wd3[31] ? qa.pop_front() : qb.pop_front();
        chk(wd3[31] ? "sb_a_order" : "sb_b_order", {27'd0, wa3, wd3}, {27'd0, e});
      end
    end
  endtask
  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd);
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
  endtask
  task automatic add(input logic [31:0] av, ard, ad, bv, brd, bd, ear, ebr, ef, ewe, ewa, epend);
    vec_t v;
    v.av = av[0]; v.ard = ard[4:0]; v.ad = ad;
    v.bv = bv[0]; v.brd = brd[4:0]; v.bd = bd;
    v.ear = ear[0]; v.ebr = ebr[0]; v.ef = ef[0]; v.ewe = ewe[0];
    v.ewa = ewa[4:0]; v.epend = epend;
    tbl.push_back(v);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we3", 64'(we3), 64'd0);
    chk("rst_wa3", 64'(wa3), 64'd0);
    chk("rst_wd3", 64'(wd3), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    rstn = 1'b1;
    #1;
`ifndef WB_ARBITER_BYPASS_EN
    add(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 1, 0, 1, 5, 32'h20);
    add(1, 0, 32'h80000000, 0, 0, 0, 1, 1, 0, 0, 0, 32'h0);
    add(0, 0, 0, 1, 3, 3, 1, 1, 0, 0, 0, 32'h8);
    add(0, 0, 0, 1, 7, 7, 1, 1, 0, 1, 3, 32'h88);
    add(0, 0, 0, 1, 9, 9, 1, 1, 0, 1, 7, 32'h280);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 9, 32'h200);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 9, 32'h0);
    add(1, 1, 32'h80000001, 1, 10, 10, 1, 1, 0, 1, 1, 32'h402);
    add(1, 1, 32'h80000002, 1, 11, 11, 1, 1, 0, 1, 1, 32'hC02);
    add(1, 1, 32'h80000003, 1, 12, 12, 1, 1, 0, 1, 1, 32'h1C02);
    add(1, 1, 32'h80000004, 1, 13, 13, 1, 1, 0, 1, 1, 32'h3C02);
    add(1, 1, 32'h80000005, 1, 14, 14, 1, 0, 1, 1, 1, 32'h3C02);
    add(1, 1, 32'h80000006, 1, 14, 14, 0, 1, 1, 1, 10, 32'h7C00);
    add(1, 1, 32'h80000007, 0, 0, 0, 1, 0, 1, 1, 1, 32'h7802);
    add(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 11, 32'h7800);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 12, 32'h7000);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 13, 32'h6000);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 14, 32'h4000);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 14, 32'h0);
    foreach (tbl[i]) begin
      drive(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].bv, tbl[i].brd, tbl[i].bd);
      #1;
      chk($sformatf("row%0d_a_ready", i), 64'(a_ready), 64'(tbl[i].ear));
      chk($sformatf("row%0d_b_ready", i), 64'(b_ready), 64'(tbl[i].ebr));
      chk($sformatf("row%0d_fifo_full", i), 64'(fifo_full), 64'(tbl[i].ef));
      tick();
      chk($sformatf("row%0d_we3", i), 64'(we3), 64'(tbl[i].ewe));
      chk($sformatf("row%0d_wa3", i), 64'(wa3), 64'(tbl[i].ewa));
      chk($sformatf("row%0d_pending", i), 64'(pending), 64'(tbl[i].epend));
    end
`else
    drive(0, 0, 0, 1, 12, 1);
    #1;
    tick();
    chk("byp_we3", 64'(we3), 64'd1);
    chk("byp_wa3", 64'(wa3), 64'd12);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("byp_no_push_we3", 64'(we3), 64'd0);
    chk("byp_no_push_pending", 64'(pending), 64'd0);
`endif
    // sustained B traffic against random A pressure forces full-FIFO push/pop and pointer wrap
    for (int k = 0; k < 40; k++) begin
      drive(1'($urandom_range(0, 1)), 5'(1 + k % 8), 32'h80000000 | k, 1'b1, 5'(16 + k % 16), 32'(100 + k));
      #1;
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 50 && (qa.size() + qb.size()) != 0; n++) tick();
    chk("drain_empty", 64'(qa.size() + qb.size()), 64'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 2, 32'h80000100 | k, 1, 5'(20 + k), 32'(200 + k));
      #1;
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    rstn = 1'b0;
    #1;
    chk("async_rst_we3", 64'(we3), 64'd0);
    chk("async_rst_wa3", 64'(wa3), 64'd0);
    chk("async_rst_wd3", 64'(wd3), 64'd0);
    chk("async_rst_pending", 64'(pending), 64'd0);
    qa.delete();
    qb.delete();
    #2;
    rstn = 1'b1;
    #1;
    chk("post_rst_b_ready", 64'(b_ready), 64'd1);
    chk("post_rst_fifo_full", 64'(fifo_full), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_discarded", 64'(we3), 64'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
